// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment display blocks.
package sevenseg_pkg;

  // Bit positions of each segment on the active-low segment bus.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // All segments dark (active-low).
  localparam logic [6:0] SEGS_OFF = 7'h7F;

  // All anodes off for the widest supported bank; slice to the digit count.
  localparam int unsigned MAX_DIGITS = 16;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/sevenseg_hex.sv
// Hex nibble to active-low seven-segment pattern, [6]=g .. [0]=a.
module sevenseg_hex
  import sevenseg_pkg::*;
(
  input  logic [3:0] data,
  output logic [6:0] segs_l
);

  localparam logic [6:0] M_A = 7'd1 << SEG_A;
  localparam logic [6:0] M_B = 7'd1 << SEG_B;
  localparam logic [6:0] M_C = 7'd1 << SEG_C;
  localparam logic [6:0] M_D = 7'd1 << SEG_D;
  localparam logic [6:0] M_E = 7'd1 << SEG_E;
  localparam logic [6:0] M_F = 7'd1 << SEG_F;
  localparam logic [6:0] M_G = 7'd1 << SEG_G;

  logic [6:0] on;

  // Font as lit-segment sets, inverted onto the active-low bus.
  always_comb begin
    on = '0;
    unique case (data)
      4'h0: on = M_A | M_B | M_C | M_D | M_E | M_F;
      4'h1: on = M_B | M_C;
      4'h2: on = M_A | M_B | M_D | M_E | M_G;
      4'h3: on = M_A | M_B | M_C | M_D | M_G;
      4'h4: on = M_B | M_C | M_F | M_G;
      4'h5: on = M_A | M_C | M_D | M_F | M_G;
      4'h6: on = M_A | M_C | M_D | M_E | M_F | M_G;
      4'h7: on = M_A | M_B | M_C;
      4'h8: on = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
      4'h9: on = M_A | M_B | M_C | M_D | M_F | M_G;
      4'hA: on = M_A | M_B | M_C | M_E | M_F | M_G;
      4'hB: on = M_C | M_D | M_E | M_F | M_G;
      4'hC: on = M_A | M_D | M_E | M_F;
      4'hD: on = M_B | M_C | M_D | M_E | M_G;
      4'hE: on = M_A | M_D | M_E | M_F | M_G;
      4'hF: on = M_A | M_E | M_F | M_G;
      default: on = '0;
    endcase
    segs_l = SEGS_OFF & ~on;
  end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Inputs are shadowed once per frame; each slot opens with an anode-off
// blanking interval, and all display outputs are registered.
module sevenseg_scan_ctl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS = 8,
  parameter int unsigned DIV     = 1000,
  parameter int unsigned BLANK   = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     en,
  output logic [NDIGITS-1:0]     an_l,
  output logic [6:0]             segs_l,
  output logic                   dp_l,
  output logic                   frame_tick
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(NDIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  localparam logic [NDIGITS-1:0] AN_ALL_OFF = AN_OFF[NDIGITS-1:0];

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIGITS-1:0] sh_data_q, sh_data_d;
  logic [NDIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NDIGITS-1:0]   sh_en_q, sh_en_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [NDIGITS-1:0]   an_l_q, an_l_d;
  logic [6:0]           segs_l_q, segs_l_d;
  logic                 dp_l_q, dp_l_d;

  logic                 slot_end;
  logic                 frame_end;
  logic [3:0]           cur_nib;
  logic                 cur_en;
  logic                 cur_dp;
  logic                 lit;
  logic [6:0]           hex_segs_l;

  // Slot counter, digit index and frame-boundary shadow capture.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    sh_data_d    = frame_end ? data : sh_data_q;
    sh_dp_d      = frame_end ? dp   : sh_dp_q;
    sh_en_d      = frame_end ? en   : sh_en_q;
    frame_tick_d = frame_end;
  end

  // Select the shadowed nibble, enable and decimal point of the current digit.
  always_comb begin
    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = sh_data_q[4*i +: 4];
        cur_en  = sh_en_q[i];
        cur_dp  = sh_dp_q[i];
      end
    end
  end

  sevenseg_hex u_hex (
    .data   (cur_nib),
    .segs_l (hex_segs_l)
  );

  // Slot function: light the current digit only past the blanking interval.
  always_comb begin
    lit      = (cnt_q >= CNT_LIT) && cur_en;
    an_l_d   = AN_ALL_OFF;
    segs_l_d = SEGS_OFF;
    dp_l_d   = 1'b1;
    if (lit) begin
      an_l_d   = ~(NDIGITS'(1) << idx_q);
      segs_l_d = hex_segs_l;
      dp_l_d   = ~cur_dp;
    end
  end

  // State and output registers; reset forces the display dark at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      frame_tick_q <= 1'b0;
      an_l_q       <= AN_ALL_OFF;
      segs_l_q     <= SEGS_OFF;
      dp_l_q       <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      frame_tick_q <= frame_tick_d;
      an_l_q       <= an_l_d;
      segs_l_q     <= segs_l_d;
      dp_l_q       <= dp_l_d;
    end
  end

  assign an_l       = an_l_q;
  assign segs_l     = segs_l_q;
  assign dp_l       = dp_l_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Directed bench for sevenseg_scan_ctl with NDIGITS=4, DIV=4, BLANK=1.
// Cycle n is the n-th clock period after reset release; each slot's
// outputs occupy cycles 4k+1..4k+4 (one blank cycle then three lit).
module tb_sevenseg_scan_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [3:0]  an_l;
  logic [6:0]  segs_l;
  logic        dp_l;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Standard active-low hex font, [6]=g .. [0]=a.
  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan_ctl #(.NDIGITS(4), .DIV(4), .BLANK(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .dp         (dp),
    .en         (en),
    .an_l       (an_l),
    .segs_l     (segs_l),
    .dp_l       (dp_l),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Advance to the next sample point, 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_dark(input string tag, input logic ft);
    chk({tag, ".an"}, 32'(an_l), 32'h0000000F);
    chk({tag, ".segs"}, 32'(segs_l), 32'h0000007F);
    chk({tag, ".dp"}, 32'(dp_l), 32'h1);
    chk({tag, ".ft"}, 32'(frame_tick), 32'(ft));
  endtask

  // One slot: blank cycle, then three cycles either lit as given or dark.
  task automatic slot_check(input string tag, input logic lit, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e, input logic ft_last);
    tick();
    chk_dark({tag, ".blank"}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lit) begin
        chk({tag, ".an"}, 32'(an_l), 32'(an_e));
        chk({tag, ".segs"}, 32'(segs_l), 32'(seg_e));
        chk({tag, ".dp"}, 32'(dp_l), 32'(dp_e));
        chk({tag, ".ft"}, 32'(frame_tick), 32'((i == 2) && ft_last));
      end else begin
        chk_dark(tag, (i == 2) && ft_last);
      end
    end
  endtask

  task automatic dark_frame(input string tag);
    slot_check({tag, "d0"}, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    slot_check({tag, "d1"}, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    slot_check({tag, "d2"}, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    slot_check({tag, "d3"}, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    data    = 16'h1234;
    dp      = 4'h0;
    en      = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk_dark("reset", 1'b0);

    // Release; cycle 0 sampled immediately after.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    cyc = 0;
    chk_dark("c0", 1'b0);

    // Frame 0 dark, frame_tick in cycle 16.
    dark_frame("f0");

    // Frame 1 shows 4,3,2,1; data changes mid-frame at cycle 20.
    slot_check("f1d0", 1'b1, 4'b1110, 7'h19, 1'b1, 1'b0);
    data = 16'hFFFF;
    slot_check("f1d1", 1'b1, 4'b1101, 7'h30, 1'b1, 1'b0);
    slot_check("f1d2", 1'b1, 4'b1011, 7'h24, 1'b1, 1'b0);
    slot_check("f1d3", 1'b1, 4'b0111, 7'h79, 1'b1, 1'b1);

    // Frame 2 shows F everywhere; next inputs set at cycle 44.
    slot_check("f2d0", 1'b1, 4'b1110, 7'h0E, 1'b1, 1'b0);
    slot_check("f2d1", 1'b1, 4'b1101, 7'h0E, 1'b1, 1'b0);
    slot_check("f2d2", 1'b1, 4'b1011, 7'h0E, 1'b1, 1'b0);
    en   = 4'b0101;
    dp   = 4'b0001;
    data = 16'h7E8D;
    slot_check("f2d3", 1'b1, 4'b0111, 7'h0E, 1'b1, 1'b1);

    // Frame 3: digits 1 and 3 disabled, dp only on digit 0.
    en   = 4'b0001;
    dp   = 4'b0000;
    data = 16'h0000;
    slot_check("f3d0", 1'b1, 4'b1110, 7'h21, 1'b0, 1'b0);
    slot_check("f3d1", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
    slot_check("f3d2", 1'b1, 4'b1011, 7'h06, 1'b1, 1'b0);
    slot_check("f3d3", 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);

    // Font sweep on digit 0, value v visible one frame after it is set.
    for (int v = 0; v < 16; v++) begin
      if (v < 15) begin
        data = 16'(v + 1);
      end else begin
        data = 16'h1234;
        en   = 4'hF;
      end
      slot_check($sformatf("sweep%0d", v), 1'b1, 4'b1110, FONT[v], 1'b1, 1'b0);
      slot_check($sformatf("sweep%0d.d1", v), 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
      slot_check($sformatf("sweep%0d.d2", v), 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
      slot_check($sformatf("sweep%0d.d3", v), 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
    end

    // Reset mid-slot of digit 2.
    slot_check("r0", 1'b1, 4'b1110, 7'h19, 1'b1, 1'b0);
    slot_check("r1", 1'b1, 4'b1101, 7'h30, 1'b1, 1'b0);
    tick();
    chk_dark("r2.blank", 1'b0);
    tick();
    chk("r2.an", 32'(an_l), 32'(4'b1011));
    chk("r2.segs", 32'(segs_l), 32'(7'h24));
    reset_n = 1'b0;
    #1;
    chk_dark("rst.async", 1'b0);
    repeat (3) @(negedge clk);
    chk_dark("rst.hold", 1'b0);
    reset_n = 1'b1;
    #1;
    cyc = 0;
    chk_dark("rst.c0", 1'b0);
    dark_frame("rstf0");
    slot_check("rstf1d0", 1'b1, 4'b1110, 7'h19, 1'b1, 1'b0);

    // Random data/en: at most one anode low, blank at the start of every slot.
    for (int i = 0; i < 1000; i++) begin
      data = 16'($urandom);
      en   = 4'($urandom);
      dp   = 4'($urandom);
      tick();
      chk("onehot", 32'($countones(~an_l) <= 1), 32'h1);
      if ((cyc % 4) == 1) begin
        chk("slotblank", 32'(an_l), 32'h0000000F);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
